// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath/memory it steers:
// instruction and flag inputs, memory handshake, and all strobes.
interface control_sequencer_if;
  logic [7:0] ir;
  logic [3:0] flags;
  logic       mem_rdy;
  logic       irq;
  logic       mem_oe;
  logic       mem_we;
  logic       addr_dp;
  logic       inc_ip;
  logic       p_selector;
  logic       we_ir;
  logic       d_to_di;
  logic       alu_oe;
  logic       flags_we;
  logic [3:0] reg_we;
  logic [3:0] reg_alu_oe;
  logic       a_to_d;
  logic       b_to_d;
  logic       irq_ack;
  logic       timeout_err;
  logic [2:0] state;

  modport master (
    input  ir, flags, mem_rdy, irq,
    output mem_oe, mem_we, addr_dp, inc_ip, p_selector,
    output we_ir, d_to_di, alu_oe, flags_we, reg_we, reg_alu_oe, a_to_d, b_to_d,
    output irq_ack, timeout_err, state
  );

  modport slave (
    output ir, flags, mem_rdy, irq,
    input  mem_oe, mem_we, addr_dp, inc_ip, p_selector,
    input  we_ir, d_to_di, alu_oe, flags_we, reg_we, reg_alu_oe, a_to_d, b_to_d,
    input  irq_ack, timeout_err, state
  );
endinterface

// File: rtl/control_sequencer.sv
// Micro-sequencer for an 8-bit accumulator CPU: fetch/execute FSM with
// immediate loads, conditional IP/DP swap jumps, interrupt entry and a memory watchdog.
module control_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4,
  parameter int IRQ_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  control_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    IMM   = 3'd2,
    IRQ   = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam int              TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_LAST_I);

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             p_sel_q;
  logic             tmo_q;

  logic       is_alu, is_ld, is_st, is_ldi;
  logic [1:0] idx;
  logic       cond;
  logic       irq_take;

  logic       mem_access;
  logic       jump_tgl;
  logic       mem_oe_c, mem_we_c, addr_dp_c, inc_ip_c;
  logic       we_ir_c, d_to_di_c, alu_oe_c, flags_we_c;
  logic [3:0] reg_we_c, reg_alu_oe_c;
  logic       a_to_d_c, b_to_d_c, irq_ack_c;

  assign is_alu   = ~bus.ir[7];
  assign is_ld    = (bus.ir[7:5] == 3'b100);
  assign is_st    = (bus.ir[7:5] == 3'b101);
  assign is_ldi   = (bus.ir[7:5] == 3'b110);
  assign idx      = bus.ir[1:0];
  // JMP forces true via ir[3]; NOP sets ir[2] as well, which inverts it back to false.
  assign cond     = (bus.ir[3] ? 1'b1 : bus.flags[bus.ir[1:0]]) ^ bus.ir[2];
  assign irq_take = (IRQ_EN != 0) && bus.irq;

  always_comb begin
    state_nxt    = state_q;
    mem_access   = 1'b0;
    jump_tgl     = 1'b0;
    mem_oe_c     = 1'b0;
    mem_we_c     = 1'b0;
    addr_dp_c    = 1'b0;
    inc_ip_c     = 1'b0;
    we_ir_c      = 1'b0;
    d_to_di_c    = 1'b0;
    alu_oe_c     = 1'b0;
    flags_we_c   = 1'b0;
    reg_we_c     = 4'b0000;
    reg_alu_oe_c = 4'b0000;
    a_to_d_c     = 1'b0;
    b_to_d_c     = 1'b0;
    irq_ack_c    = 1'b0;

    case (state_q)
      FETCH: begin
        mem_oe_c   = 1'b1;
        mem_access = 1'b1;
        if (bus.mem_rdy) begin
          if (irq_take) begin
            state_nxt = IRQ;
          end else begin
            we_ir_c   = 1'b1;
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        if (is_alu) begin
          reg_alu_oe_c[idx]                 = 1'b1;
          alu_oe_c                          = 1'b1;
          reg_we_c[bus.ir[2] ? idx : 2'd0]  = 1'b1;
          flags_we_c                        = (bus.ir[6:3] != 4'b1000);
          inc_ip_c                          = 1'b1;
          state_nxt                         = FETCH;
        end else if (is_ld) begin
          addr_dp_c  = 1'b1;
          mem_oe_c   = 1'b1;
          mem_access = 1'b1;
          if (bus.mem_rdy) begin
            d_to_di_c     = 1'b1;
            reg_we_c[idx] = 1'b1;
            inc_ip_c      = 1'b1;
            state_nxt     = FETCH;
          end
        end else if (is_st) begin
          addr_dp_c  = 1'b1;
          mem_we_c   = 1'b1;
          a_to_d_c   = ~bus.ir[0];
          b_to_d_c   = bus.ir[0];
          mem_access = 1'b1;
          if (bus.mem_rdy) begin
            inc_ip_c  = 1'b1;
            state_nxt = FETCH;
          end
        end else if (is_ldi) begin
          inc_ip_c  = 1'b1;
          state_nxt = IMM;
        end else begin
          inc_ip_c  = 1'b1;
          jump_tgl  = cond;
          state_nxt = FETCH;
        end
      end
      IMM: begin
        mem_oe_c   = 1'b1;
        mem_access = 1'b1;
        if (bus.mem_rdy) begin
          d_to_di_c     = 1'b1;
          reg_we_c[idx] = 1'b1;
          inc_ip_c      = 1'b1;
          state_nxt     = FETCH;
        end
      end
      IRQ: begin
        irq_ack_c = (IRQ_EN != 0);
        state_nxt = FETCH;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase

    // Watchdog: the access has already waited TIMEOUT-1 cycles and is still not ready.
    if ((TIMEOUT > 0) && mem_access && !bus.mem_rdy && (wait_cnt == TO_LAST))
      state_nxt = HALT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      p_sel_q  <= 1'b0;
      wait_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_nxt == HALT)
        tmo_q <= 1'b1;
      if (jump_tgl || (state_q == IRQ))
        p_sel_q <= ~p_sel_q;
      if (mem_access && !bus.mem_rdy && (state_nxt == state_q))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  // Write strobes, inc_ip and irq_ack are forced low while reset is held.
  assign bus.mem_oe      = mem_oe_c;
  assign bus.addr_dp     = addr_dp_c;
  assign bus.d_to_di     = d_to_di_c;
  assign bus.alu_oe      = alu_oe_c;
  assign bus.reg_alu_oe  = reg_alu_oe_c;
  assign bus.a_to_d      = a_to_d_c;
  assign bus.b_to_d      = b_to_d_c;
  assign bus.mem_we      = mem_we_c   & ~rst;
  assign bus.inc_ip      = inc_ip_c   & ~rst;
  assign bus.we_ir       = we_ir_c    & ~rst;
  assign bus.flags_we    = flags_we_c & ~rst;
  assign bus.irq_ack     = irq_ack_c  & ~rst;
  assign bus.reg_we      = rst ? 4'b0000 : reg_we_c;
  assign bus.p_selector  = p_sel_q;
  assign bus.timeout_err = tmo_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected output snapshots are queued
// as each cycle's stimulus is applied and checked mid-cycle against the DUT.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  control_sequencer_if bus ();

  control_sequencer #(.TIMEOUT(15), .CNT_W(4), .IRQ_EN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] state;
    logic       p_selector;
    logic       timeout_err;
    logic       irq_ack;
    logic       mem_oe;
    logic       mem_we;
    logic       addr_dp;
    logic       inc_ip;
    logic       we_ir;
    logic       d_to_di;
    logic       alu_oe;
    logic       flags_we;
    logic [3:0] reg_we;
    logic [3:0] reg_alu_oe;
    logic       a_to_d;
    logic       b_to_d;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic obs_t base(logic [2:0] s, logic p, logic t);
    obs_t o;
    o = '0;
    o.state       = s;
    o.p_selector  = p;
    o.timeout_err = t;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.state       = bus.state;
    o.p_selector  = bus.p_selector;
    o.timeout_err = bus.timeout_err;
    o.irq_ack     = bus.irq_ack;
    o.mem_oe      = bus.mem_oe;
    o.mem_we      = bus.mem_we;
    o.addr_dp     = bus.addr_dp;
    o.inc_ip      = bus.inc_ip;
    o.we_ir       = bus.we_ir;
    o.d_to_di     = bus.d_to_di;
    o.alu_oe      = bus.alu_oe;
    o.flags_we    = bus.flags_we;
    o.reg_we      = bus.reg_we;
    o.reg_alu_oe  = bus.reg_alu_oe;
    o.a_to_d      = bus.a_to_d;
    o.b_to_d      = bus.b_to_d;
    return o;
  endfunction

  // Queue the expectation for the current cycle, check it at the falling edge,
  // then advance past the next rising edge so inputs can be changed safely.
  task automatic cyc(input string tag, input obs_t e);
    exp_t x;
    obs_t got;
    sb.push_back('{tag: tag, v: e});
    @(negedge clk);
    x   = sb.pop_front();
    got = sample();
    tests++;
    assert (got === x.v)
      else begin
        fails++;
        $error("FAIL %s: got %h expected %h", x.tag, got, x.v);
      end
    @(posedge clk);
    #1;
  endtask

  initial begin
    obs_t e;
    rst         = 1'b1;
    bus.ir      = 8'h00;
    bus.flags   = 4'h0;
    bus.mem_rdy = 1'b1;
    bus.irq     = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: FETCH, strobes suppressed even though mem_rdy is high.
    e = base(3'd0, 1'b0, 1'b0); e.mem_oe = 1'b1;
    cyc("reset_fetch", e);
    rst    = 1'b0;
    bus.ir = 8'h01;

    // ALU op0000 idx1 dir0.
    e = base(3'd0, 1'b0, 1'b0); e.mem_oe = 1'b1; e.we_ir = 1'b1;
    cyc("alu01_fetch", e);
    e = base(3'd1, 1'b0, 1'b0); e.reg_alu_oe = 4'b0010; e.alu_oe = 1'b1;
    e.reg_we = 4'b0001; e.flags_we = 1'b1; e.inc_ip = 1'b1;
    cyc("alu01_exec", e);

    // ALU op1000 (no flags) idx2 dir1.
    bus.ir = 8'h46;
    e = base(3'd0, 1'b0, 1'b0); e.mem_oe = 1'b1; e.we_ir = 1'b1;
    cyc("alu46_fetch", e);
    e = base(3'd1, 1'b0, 1'b0); e.reg_alu_oe = 4'b0100; e.alu_oe = 1'b1;
    e.reg_we = 4'b0100; e.inc_ip = 1'b1;
    cyc("alu46_exec", e);

    // LDI with three wait cycles in IMM.
    bus.ir = 8'hC2;
    e = base(3'd0, 1'b0, 1'b0); e.mem_oe = 1'b1; e.we_ir = 1'b1;
    cyc("ldi_fetch", e);
    e = base(3'd1, 1'b0, 1'b0); e.inc_ip = 1'b1;
    cyc("ldi_exec", e);
    bus.mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = base(3'd2, 1'b0, 1'b0); e.mem_oe = 1'b1;
      cyc("ldi_imm_wait", e);
    end
    bus.mem_rdy = 1'b1;
    e = base(3'd2, 1'b0, 1'b0); e.mem_oe = 1'b1; e.d_to_di = 1'b1;
    e.reg_we = 4'b0100; e.inc_ip = 1'b1;
    cyc("ldi_imm_done", e);

    // LD idx3 with one wait cycle.
    bus.ir = 8'h83;
    e = base(3'd0, 1'b0, 1'b0); e.mem_oe = 1'b1; e.we_ir = 1'b1;
    cyc("ld_fetch", e);
    bus.mem_rdy = 1'b0;
    e = base(3'd1, 1'b0, 1'b0); e.mem_oe = 1'b1; e.addr_dp = 1'b1;
    cyc("ld_wait", e);
    bus.mem_rdy = 1'b1;
    e = base(3'd1, 1'b0, 1'b0); e.mem_oe = 1'b1; e.addr_dp = 1'b1;
    e.d_to_di = 1'b1; e.reg_we = 4'b1000; e.inc_ip = 1'b1;
    cyc("ld_done", e);

    // Jc taken, Jc not taken, NOP.
    bus.ir = 8'hE1; bus.flags = 4'b0010;
    e = base(3'd0, 1'b0, 1'b0); e.mem_oe = 1'b1; e.we_ir = 1'b1;
    cyc("jc_t_fetch", e);
    e = base(3'd1, 1'b0, 1'b0); e.inc_ip = 1'b1;
    cyc("jc_t_exec", e);
    bus.flags = 4'b0000;
    e = base(3'd0, 1'b1, 1'b0); e.mem_oe = 1'b1; e.we_ir = 1'b1;
    cyc("jc_n_fetch", e);
    e = base(3'd1, 1'b1, 1'b0); e.inc_ip = 1'b1;
    cyc("jc_n_exec", e);
    bus.ir = 8'hEC;
    e = base(3'd0, 1'b1, 1'b0); e.mem_oe = 1'b1; e.we_ir = 1'b1;
    cyc("nop_fetch", e);
    e = base(3'd1, 1'b1, 1'b0); e.inc_ip = 1'b1;
    cyc("nop_exec", e);

    // Interrupt at an instruction boundary: irq beats mem_rdy.
    bus.irq = 1'b1;
    e = base(3'd0, 1'b1, 1'b0); e.mem_oe = 1'b1;
    cyc("irq_fetch", e);
    bus.irq = 1'b0;
    e = base(3'd3, 1'b1, 1'b0); e.irq_ack = 1'b1;
    cyc("irq_state", e);
    bus.mem_rdy = 1'b0;
    e = base(3'd0, 1'b0, 1'b0); e.mem_oe = 1'b1;
    cyc("irq_back_fetch", e);

    // Reset asserted in the middle of a store.
    bus.ir = 8'hA0; bus.mem_rdy = 1'b1;
    e = base(3'd0, 1'b0, 1'b0); e.mem_oe = 1'b1; e.we_ir = 1'b1;
    cyc("st0_fetch", e);
    bus.mem_rdy = 1'b0;
    e = base(3'd1, 1'b0, 1'b0); e.mem_we = 1'b1; e.addr_dp = 1'b1; e.a_to_d = 1'b1;
    cyc("st0_wait", e);
    rst = 1'b1;
    e = base(3'd1, 1'b0, 1'b0); e.addr_dp = 1'b1; e.a_to_d = 1'b1;
    cyc("st0_rst_gate", e);
    rst = 1'b0;

    // Store that never completes trips the watchdog after 15 cycles.
    bus.ir = 8'hA1; bus.mem_rdy = 1'b1;
    e = base(3'd0, 1'b0, 1'b0); e.mem_oe = 1'b1; e.we_ir = 1'b1;
    cyc("st1_fetch", e);
    bus.mem_rdy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      e = base(3'd1, 1'b0, 1'b0); e.mem_we = 1'b1; e.addr_dp = 1'b1; e.b_to_d = 1'b1;
      cyc("st1_wait", e);
    end
    e = base(3'd4, 1'b0, 1'b1);
    cyc("halt", e);
    bus.mem_rdy = 1'b1;
    e = base(3'd4, 1'b0, 1'b1);
    cyc("halt_sticky", e);
    rst = 1'b1;
    e = base(3'd4, 1'b0, 1'b1);
    cyc("halt_rst_cycle", e);
    rst = 1'b0; bus.mem_rdy = 1'b0;
    e = base(3'd0, 1'b0, 1'b0); e.mem_oe = 1'b1;
    cyc("after_halt_reset", e);

    tests++;
    assert (sb.size() == 0)
      else begin
        fails++;
        $error("FAIL sb_empty: got %0d expected 0", sb.size());
      end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
